// File: rtl/video_pkg.sv
// Shared video constants: map entry layout, tile geometry and the horizontal counter range.
package video_pkg;

    localparam int unsigned FLIP_BIT  = 15;
    localparam int unsigned CODE_LSB  = 0;
    localparam int unsigned TILE_W    = 8;
    localparam int unsigned TILE_H    = 8;
    localparam int unsigned HPOS_WRAP = 512;

    // Palette field sits directly above the tile code in a map entry.
    function automatic int unsigned pal_lsb(int unsigned code_bits);
        return code_bits;
    endfunction

endpackage

// File: rtl/bg_tilemap_gen_if.sv
// Memory-side bus of the background generator: tile-map read port and char ROM read port.
interface bg_tilemap_gen_if #(
    parameter int unsigned MAP_AW    = 10,
    parameter int unsigned CODE_BITS = 9,
    parameter int unsigned BPP       = 2
);

    logic [MAP_AW-1:0]      map_addr;
    logic [15:0]            map_data;
    logic [CODE_BITS+2:0]   rom_addr;
    logic [8*BPP-1:0]       rom_data;

    modport master (
        output map_addr,
        output rom_addr,
        input  map_data,
        input  rom_data
    );

    modport slave (
        input  map_addr,
        input  rom_addr,
        output map_data,
        output rom_data
    );

endinterface

// File: rtl/bg_scroll_regs.sv
// Pending/active X/Y scroll registers; active values only move on a VBLANK rising edge.
module bg_scroll_regs
    import video_pkg::*;
(
    input  logic                           VCLK,
    input  logic                           reset,
    input  logic                           VBLANK,
    input  logic                           scroll_we,
    input  logic [$clog2(HPOS_WRAP)-1:0]   scroll_x_in,
    input  logic [$clog2(HPOS_WRAP)-1:0]   scroll_y_in,
    output logic [$clog2(HPOS_WRAP)-1:0]   sx,
    output logic [$clog2(HPOS_WRAP)-1:0]   sy
);

    localparam int unsigned PosW = $clog2(HPOS_WRAP);

    logic            vblank_q;
    logic            vblank_rise;
    logic [PosW-1:0] pend_x_q, pend_y_q;
    logic [PosW-1:0] act_x_q, act_y_q;

    assign vblank_rise = VBLANK && !vblank_q;

    always_ff @(posedge VCLK) begin
        if (reset) begin
            vblank_q <= 1'b0;
            pend_x_q <= '0;
            pend_y_q <= '0;
            act_x_q  <= '0;
            act_y_q  <= '0;
        end else begin
            vblank_q <= VBLANK;
            if (scroll_we) begin
                pend_x_q <= scroll_x_in;
                pend_y_q <= scroll_y_in;
            end
            // A write landing on the edge bypasses the pending copy.
            if (vblank_rise) begin
                act_x_q <= scroll_we ? scroll_x_in : pend_x_q;
                act_y_q <= scroll_we ? scroll_y_in : pend_y_q;
            end
        end
    end

    assign sx = act_x_q;
    assign sy = act_y_q;

endmodule

// File: rtl/bg_tilemap_gen.sv
// Scrolling background layer: fetches map entry and ROM row per tile, emits one pixel per VCLK.
module bg_tilemap_gen
    import video_pkg::*;
#(
    parameter int unsigned BPP           = 2,
    parameter int unsigned PAL_BITS      = 6,
    parameter int unsigned CODE_BITS     = 9,
    parameter int unsigned MAP_COLS_LOG2 = 5,
    parameter int unsigned MAP_ROWS_LOG2 = 5,
    parameter int unsigned MAP_COLMAJOR  = 1
) (
    input  logic                      VCLK,
    input  logic                      reset,
    input  logic [8:0]                HPOS,
    input  logic [8:0]                VPOS,
    input  logic                      VBLANK,
    input  logic                      scroll_we,
    input  logic [8:0]                scroll_x_in,
    input  logic [8:0]                scroll_y_in,
    input  logic                      layer_en,
    bg_tilemap_gen_if.master          mem,
    output logic [PAL_BITS+BPP-1:0]   pix_out,
    output logic                      pix_opaque
);

    localparam int unsigned PosW   = $clog2(HPOS_WRAP);
    localparam int unsigned FineW  = $clog2(TILE_W);
    localparam int unsigned LineW  = $clog2(TILE_H);
    localparam int unsigned MapAw  = MAP_COLS_LOG2 + MAP_ROWS_LOG2;
    localparam int unsigned RomAw  = CODE_BITS + LineW;
    localparam int unsigned RowW   = TILE_W * BPP;
    localparam int unsigned PalLsb = pal_lsb(CODE_BITS);

    logic [PosW-1:0]          sx, sy, ax, ay;
    logic [FineW-1:0]         fine_x, pix_idx;
    logic [LineW-1:0]         line;
    logic [MAP_COLS_LOG2-1:0] map_col;
    logic [MAP_ROWS_LOG2-1:0] map_row;
    logic [MapAw-1:0]         map_addr_new, map_addr_q;
    logic [RomAw-1:0]         rom_addr_new, rom_addr_q;
    logic                     ph_map, ph_rom, ph_load;
    logic [PAL_BITS-1:0]      pal_nxt_q, pal_q;
    logic                     flip_nxt_q;
    logic [RowW-1:0]          row_q, row_rev;
    logic [BPP-1:0]           pix_bits;

    bg_scroll_regs u_scroll (
        .VCLK        (VCLK),
        .reset       (reset),
        .VBLANK      (VBLANK),
        .scroll_we   (scroll_we),
        .scroll_x_in (scroll_x_in),
        .scroll_y_in (scroll_y_in),
        .sx          (sx),
        .sy          (sy)
    );

    // During hblank (HPOS[8]) the fetches already target the next line.
    assign ax     = HPOS + sx;
    assign ay     = VPOS + sy + {{(PosW-1){1'b0}}, HPOS[PosW-1]};
    assign fine_x = ax[FineW-1:0];
    assign line   = ay[LineW-1:0];

    assign ph_map  = (fine_x == FineW'(5));
    assign ph_rom  = (fine_x == FineW'(6));
    assign ph_load = (fine_x == FineW'(7));

    assign map_col      = MAP_COLS_LOG2'((ax >> FineW) + PosW'(1));
    assign map_row      = MAP_ROWS_LOG2'(ay >> FineW);
    assign map_addr_new = (MAP_COLMAJOR != 0) ? {map_col, map_row} : {map_row, map_col};
    assign rom_addr_new = {mem.map_data[CODE_LSB +: CODE_BITS], line};

    assign mem.map_addr = ph_map ? map_addr_new : map_addr_q;
    assign mem.rom_addr = ph_rom ? rom_addr_new : rom_addr_q;

    always_comb begin
        row_rev = '0;
        for (int p = 0; p < TILE_W; p++) begin
            row_rev[p*BPP +: BPP] = mem.rom_data[(TILE_W-1-p)*BPP +: BPP];
        end
    end

    always_ff @(posedge VCLK) begin
        if (reset) begin
            map_addr_q <= '0;
            rom_addr_q <= '0;
            pal_nxt_q  <= '0;
            flip_nxt_q <= 1'b0;
            pal_q      <= '0;
            row_q      <= '0;
        end else begin
            if (ph_map) map_addr_q <= map_addr_new;
            if (ph_rom) begin
                rom_addr_q <= rom_addr_new;
                pal_nxt_q  <= mem.map_data[PalLsb +: PAL_BITS];
                flip_nxt_q <= mem.map_data[FLIP_BIT];
            end
            if (ph_load) begin
                row_q <= flip_nxt_q ? row_rev : mem.rom_data;
                pal_q <= pal_nxt_q;
            end
        end
    end

    // Pixel 0 occupies the MSBs of the row.
    assign pix_idx  = FineW'(TILE_W - 1) - fine_x;
    assign pix_bits = row_q[pix_idx*BPP +: BPP];

    always_ff @(posedge VCLK) begin
        if (reset) begin
            pix_out    <= '0;
            pix_opaque <= 1'b0;
        end else begin
            pix_out    <= {pal_q, layer_en ? pix_bits : {BPP{1'b0}}};
            pix_opaque <= layer_en && (pix_bits != '0);
        end
    end

endmodule

// File: tb/tb_bg_tilemap_gen.sv
// Directed bench for bg_tilemap_gen: sync map/ROM models, hand-computed pixel rows per scenario.
module tb_bg_tilemap_gen;

    logic       VCLK = 1'b0;
    logic       reset;
    logic [8:0] HPOS, VPOS;
    logic       VBLANK, scroll_we, layer_en;
    logic [8:0] scroll_x_in, scroll_y_in;
    logic [7:0] pix_out;
    logic       pix_opaque;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] map_mem [1024];
    logic [15:0] rom_mem [4096];

    always #5 VCLK = ~VCLK;

    bg_tilemap_gen_if #(.MAP_AW(10), .CODE_BITS(9), .BPP(2)) mem ();

    bg_tilemap_gen #(
        .BPP           (2),
        .PAL_BITS      (6),
        .CODE_BITS     (9),
        .MAP_COLS_LOG2 (5),
        .MAP_ROWS_LOG2 (5),
        .MAP_COLMAJOR  (1)
    ) dut (
        .VCLK        (VCLK),
        .reset       (reset),
        .HPOS        (HPOS),
        .VPOS        (VPOS),
        .VBLANK      (VBLANK),
        .scroll_we   (scroll_we),
        .scroll_x_in (scroll_x_in),
        .scroll_y_in (scroll_y_in),
        .layer_en    (layer_en),
        .mem         (mem),
        .pix_out     (pix_out),
        .pix_opaque  (pix_opaque)
    );

    // Synchronous RAM/ROM: data valid one cycle after the address.
    always @(posedge VCLK) begin
        mem.map_data <= map_mem[mem.map_addr];
        mem.rom_data <= rom_mem[mem.rom_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs sampled here belong to the HPOS presented before this edge.
    task automatic step();
        @(posedge VCLK);
        #1;
        if (HPOS == 9'd511) begin
            HPOS = 9'd0;
            VPOS = VPOS + 9'd1;
        end else begin
            HPOS = HPOS + 9'd1;
        end
    endtask

    // Start late in the previous line so the hblank prefetch runs normally.
    task automatic seek(input logic [8:0] v, input logic [8:0] h);
        VPOS = v - 9'd1;
        HPOS = 9'd500;
        for (int n = 0; n < 600 && !(HPOS == h && VPOS == v); n++) step();
        if (!(HPOS == h && VPOS == v)) check_eq("seek_timeout", {23'd0, HPOS}, {23'd0, h});
    endtask

    task automatic check_line(input string tag, input logic [63:0] exp);
        logic [7:0] e;
        for (int i = 0; i < 8; i++) begin
            step();
            e = exp[63-8*i -: 8];
            check_eq($sformatf("%s_pix%0d", tag, i), {24'd0, pix_out}, {24'd0, e});
            check_eq($sformatf("%s_opq%0d", tag, i), {31'd0, pix_opaque},
                     {31'd0, layer_en && (e[1:0] != 2'd0)});
        end
    endtask

    task automatic set_scroll(input logic [8:0] x, input logic [8:0] y);
        scroll_x_in = x;
        scroll_y_in = y;
        scroll_we   = 1'b1;
        step();
        scroll_we   = 1'b0;
        VBLANK      = 1'b1;
        step();
        step();
        VBLANK      = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) map_mem[i] = 16'h0000;
        for (int i = 0; i < 4096; i++) rom_mem[i] = 16'h0000;
        // Map entries {flip, pal[5:0], code[8:0]}, address {col, row}.
        map_mem[0]   = 16'h0A03;   // (0,0)  pal 5 code 3
        map_mem[32]  = 16'h0404;   // (1,0)  pal 2 code 4
        map_mem[992] = 16'h0205;   // (31,0) pal 1 code 5
        map_mem[1]   = 16'h0606;   // (0,1)  pal 3 code 6
        map_mem[384] = 16'h0A03;   // (12,0)
        map_mem[416] = 16'h0A03;   // (13,0)
        map_mem[448] = 16'h0A03;   // (14,0)
        rom_mem[24]  = 16'h1E39;   // pixels 0,1,3,2,0,3,2,1
        rom_mem[32]  = 16'hE400;   // pixels 3,2,1,0,0,0,0,0
        rom_mem[40]  = 16'h5555;   // all 1
        rom_mem[48]  = 16'hFFFF;   // code 6 line 0: all 3 (line 1 stays 0)

        reset = 1'b1; HPOS = 9'd0; VPOS = 9'd0; VBLANK = 1'b0;
        scroll_we = 1'b0; scroll_x_in = 9'd0; scroll_y_in = 9'd0; layer_en = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        check_eq("reset_pix", {24'd0, pix_out}, 32'd0);
        check_eq("reset_opq", {31'd0, pix_opaque}, 32'd0);

        // Scroll 0 basic tile, then layer disabled, then flipped.
        seek(9'd0, 9'd0);
        check_line("basic", 64'h14_15_17_16_14_17_16_15);
        layer_en = 1'b0;
        seek(9'd0, 9'd0);
        check_line("layer_off", 64'h14_14_14_14_14_14_14_14);
        layer_en = 1'b1;
        map_mem[0] = 16'h8A03;
        seek(9'd0, 9'd0);
        check_line("flip", 64'h15_16_17_14_16_17_15_14);
        map_mem[0] = 16'h0A03;

        // Fine scroll: tile boundary falls between HPOS 4 and 5.
        set_scroll(9'd3, 9'd0);
        seek(9'd0, 9'd0);
        check_line("sx3", 64'h16_14_17_16_15_0B_0A_09);

        // Pending write mid-frame must not disturb the active scroll.
        seek(9'd100, 9'd0);
        scroll_x_in = 9'd16;
        scroll_we   = 1'b1;
        step();
        scroll_we   = 1'b0;
        seek(9'd0, 9'd0);
        check_line("hold", 64'h16_14_17_16_15_0B_0A_09);

        // Write coincident with the VBLANK edge goes straight to active.
        scroll_x_in = 9'd8;
        scroll_we   = 1'b1;
        VBLANK      = 1'b1;
        step();
        scroll_we   = 1'b0;
        step();
        VBLANK      = 1'b0;
        step();
        seek(9'd0, 9'd0);
        check_line("edge_we", 64'h0B_0A_09_08_08_08_08_08);

        // Column wrap 31->0 and row select via sy.
        set_scroll(9'd508, 9'd0);
        seek(9'd0, 9'd0);
        check_line("sx508", 64'h05_05_05_05_14_15_17_16);
        set_scroll(9'd0, 9'd7);
        seek(9'd1, 9'd0);
        check_line("sy7", 64'h0F_0F_0F_0F_0F_0F_0F_0F);

        // Reset mid-line, then recovery after the next tile load.
        set_scroll(9'd0, 9'd0);
        seek(9'd0, 9'd100);
        reset = 1'b1;
        step();
        check_eq("midrst_pix0", {24'd0, pix_out}, 32'd0);
        check_eq("midrst_opq0", {31'd0, pix_opaque}, 32'd0);
        step();
        check_eq("midrst_pix1", {24'd0, pix_out}, 32'd0);
        check_eq("midrst_opq1", {31'd0, pix_opaque}, 32'd0);
        reset = 1'b0;
        repeat (10) step();
        check_line("recover", 64'h14_15_17_16_14_17_16_15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
